// File: rtl/cordic_result_collector.sv
// Pairs CORDIC results with the mode/sequence tag recorded at issue time and
// buffers them in a show-ahead output FIFO, issuing credit so it never overflows.
module cordic_result_collector #(
    parameter int DEPTH = 8,
    parameter int SEQW  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iss_valid,
    input  logic [3:0]               iss_mode,
    output logic                     iss_ready,
    input  logic                     res_valid,
    input  logic [31:0]              res_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [31:0]              m_data,
    output logic [3:0]               m_mode,
    output logic [SEQW-1:0]          m_seq,
    output logic                     bad_mode,
    output logic                     proto_err,
    output logic [$clog2(DEPTH):0]   outstanding
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = 4 + SEQW;
    localparam int RW = 32 + TW;

    logic [TW-1:0]   tag_mem [DEPTH];
    logic [RW-1:0]   res_mem [DEPTH];
    logic [AW-1:0]   tag_wr_ptr_reg;
    logic [AW-1:0]   tag_rd_ptr_reg;
    logic [AW-1:0]   res_wr_ptr_reg;
    logic [AW-1:0]   res_rd_ptr_reg;
    logic [CW-1:0]   res_cnt_reg;
    logic [SEQW-1:0] seq_cnt_reg;

    logic            mode_ok;
    logic            iss_accept;
    logic            res_push;
    logic            res_pop;
    logic [RW-1:0]   push_word;
    logic [AW-1:0]   res_rd_ptr_next;
    logic [CW:0]     credit_used;

    assign mode_ok         = (iss_mode <= 4'd8);
    assign credit_used     = {1'b0, outstanding} + {1'b0, res_cnt_reg};
    assign iss_ready       = (credit_used < (CW+1)'(DEPTH));
    assign iss_accept      = iss_valid & mode_ok & iss_ready;
    // A result with nothing outstanding has no tag to pair with and is dropped.
    assign res_push        = res_valid & (outstanding != '0);
    assign res_pop         = m_valid & m_ready;
    assign push_word       = {res_data, tag_mem[tag_rd_ptr_reg]};
    assign res_rd_ptr_next = res_rd_ptr_reg + 1'b1;
    assign m_valid         = (res_cnt_reg != '0);

    always_ff @(posedge clk) begin
        if (iss_accept)
            tag_mem[tag_wr_ptr_reg] <= {iss_mode, seq_cnt_reg};
    end

    always_ff @(posedge clk) begin
        if (res_push)
            res_mem[res_wr_ptr_reg] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr_ptr_reg <= '0;
            tag_rd_ptr_reg <= '0;
            res_wr_ptr_reg <= '0;
            res_rd_ptr_reg <= '0;
            res_cnt_reg    <= '0;
            seq_cnt_reg    <= '0;
            outstanding    <= '0;
            bad_mode       <= 1'b0;
            proto_err      <= 1'b0;
            m_data         <= '0;
            m_mode         <= '0;
            m_seq          <= '0;
        end else begin
            bad_mode <= iss_valid & ~mode_ok;

            if ((iss_valid & mode_ok & ~iss_ready) | (res_valid & (outstanding == '0)))
                proto_err <= 1'b1;

            if (iss_accept) begin
                tag_wr_ptr_reg <= tag_wr_ptr_reg + 1'b1;
                seq_cnt_reg    <= seq_cnt_reg + 1'b1;
            end

            if (res_push) begin
                tag_rd_ptr_reg <= tag_rd_ptr_reg + 1'b1;
                res_wr_ptr_reg <= res_wr_ptr_reg + 1'b1;
            end

            outstanding <= outstanding + CW'(iss_accept) - CW'(res_push);

            if (res_pop)
                res_rd_ptr_reg <= res_rd_ptr_next;

            case ({res_push, res_pop})
                2'b10:   res_cnt_reg <= res_cnt_reg + 1'b1;
                2'b01:   res_cnt_reg <= res_cnt_reg - 1'b1;
                default: res_cnt_reg <= res_cnt_reg;
            endcase

            // Head registers: refill from the next stored entry on a pop, or take
            // the incoming result directly when the FIFO would otherwise go empty.
            if (res_pop) begin
                if (res_cnt_reg > CW'(1))
                    {m_data, m_mode, m_seq} <= res_mem[res_rd_ptr_next];
                else if (res_push)
                    {m_data, m_mode, m_seq} <= push_word;
            end else if (res_push && (res_cnt_reg == '0)) begin
                {m_data, m_mode, m_seq} <= push_word;
            end
        end
    end
endmodule

// File: tb/tb_cordic_result_collector.sv
// Directed self-checking bench for cordic_result_collector (DEPTH=8, SEQW=8).
module tb_cordic_result_collector;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic [3:0]  iss_mode;
    logic        iss_ready;
    logic        res_valid;
    logic [31:0] res_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_mode;
    logic [7:0]  m_seq;
    logic        bad_mode;
    logic        proto_err;
    logic [3:0]  outstanding;

    int n_cmp = 0;
    int n_mis = 0;

    cordic_result_collector #(.DEPTH(8), .SEQW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_mode(iss_mode), .iss_ready(iss_ready),
        .res_valid(res_valid), .res_data(res_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_mode(m_mode), .m_seq(m_seq),
        .bad_mode(bad_mode), .proto_err(proto_err), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [11:0] pend[$];
        logic [43:0] outq[$];
        logic [43:0] exp_item;
        logic [11:0] tag_item;
        logic [7:0]  mseq;
        logic [7:0]  last_seq;
        logic        drv_iss, drv_res;
        int issued, got, cyc;

        iss_valid = 0; iss_mode = 0; res_valid = 0; res_data = 0; m_ready = 0;
        do_reset();

        // Reset state
        check("rst_iss_ready", iss_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_bad_mode", bad_mode, 0);

        // Single cos issue, result 18 cycles later
        iss_valid = 1; iss_mode = 0;
        tick();
        iss_valid = 0;
        $display("issue mode=0");
        check("cos_outstanding", outstanding, 1);
        repeat (17) tick();
        res_valid = 1; res_data = 32'h0000B505; m_ready = 1;
        tick();
        res_valid = 0;
        $display("result data=0x0000B505");
        check("cos_m_valid", m_valid, 1);
        check("cos_m_data", m_data, 32'h0000B505);
        check("cos_m_mode", m_mode, 0);
        check("cos_m_seq", m_seq, 0);
        check("cos_outstanding0", outstanding, 0);
        tick();
        check("cos_popped", m_valid, 0);
        m_ready = 0;

        // Eight back-to-back issues fill the credit (seq continues at 1)
        for (int i = 0; i < 8; i++) begin
            iss_valid = 1; iss_mode = 4'(i);
            tick();
            $display("issue mode=%0d", i);
        end
        iss_valid = 0;
        check("full_iss_ready", iss_ready, 0);
        check("full_outstanding", outstanding, 8);
        for (int i = 0; i < 8; i++) begin
            res_valid = 1; res_data = 32'h1000 + 32'(i);
            tick();
            $display("result data=0x%08h", res_data);
        end
        res_valid = 0;
        check("buf_outstanding", outstanding, 0);
        check("buf_iss_ready", iss_ready, 0);
        check("buf_head_data", m_data, 32'h1000);
        check("buf_head_seq", m_seq, 1);
        m_ready = 1;
        tick();
        m_ready = 0;
        check("drain1_iss_ready", iss_ready, 1);
        for (int i = 1; i < 8; i++) begin
            check("drain_data", m_data, 32'h1000 + 32'(i));
            check("drain_mode", m_mode, 32'(i));
            check("drain_seq", m_seq, 32'(i + 1));
            $display("pop seq=%0d data=0x%08h", m_seq, m_data);
            m_ready = 1;
            tick();
            m_ready = 0;
        end
        check("drain_empty", m_valid, 0);

        // Invalid mode: pulse only
        iss_valid = 1; iss_mode = 9;
        tick();
        iss_valid = 0;
        $display("issue mode=9");
        check("bad_mode_pulse", bad_mode, 1);
        check("bad_outstanding", outstanding, 0);
        tick();
        check("bad_mode_clear", bad_mode, 0);
        check("bad_no_output", m_valid, 0);
        iss_valid = 1; iss_mode = 3;
        tick();
        iss_valid = 0;
        res_valid = 1; res_data = 32'h77;
        tick();
        res_valid = 0;
        check("bad_seq_unchanged", m_seq, 9);
        check("bad_next_mode", m_mode, 3);
        check("bad_proto_clean", proto_err, 0);
        m_ready = 1;
        tick();
        m_ready = 0;

        // Stray result
        res_valid = 1; res_data = 32'hDEAD;
        tick();
        res_valid = 0;
        $display("stray result");
        check("stray_proto_err", proto_err, 1);
        check("stray_m_valid", m_valid, 0);
        check("stray_outstanding", outstanding, 0);
        repeat (3) tick();
        check("proto_err_sticky", proto_err, 1);

        // Reset mid-operation: 3 outstanding, 2 buffered
        for (int i = 0; i < 5; i++) begin
            iss_valid = 1; iss_mode = 1;
            tick();
        end
        iss_valid = 0;
        for (int i = 0; i < 2; i++) begin
            res_valid = 1; res_data = 32'h500 + 32'(i);
            tick();
        end
        res_valid = 0;
        check("pre_rst_outstanding", outstanding, 3);
        check("pre_rst_m_valid", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset");
        check("arst_m_valid", m_valid, 0);
        check("arst_m_data", m_data, 0);
        check("arst_m_seq", m_seq, 0);
        check("arst_outstanding", outstanding, 0);
        check("arst_proto_err", proto_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_iss_ready", iss_ready, 1);
        res_valid = 1;
        tick();
        res_valid = 0;
        check("arst_stray_proto", proto_err, 1);
        check("arst_stray_m_valid", m_valid, 0);

        // 300 issue/result pairs with random back-pressure
        do_reset();
        issued = 0; got = 0; cyc = 0; mseq = 0; last_seq = 8'hFF;
        while (got < 300 && cyc < 6000) begin
            drv_iss   = (issued < 300) && iss_ready;
            drv_res   = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
            iss_valid = drv_iss;
            iss_mode  = 4'(issued % 9);
            res_valid = drv_res;
            res_data  = $urandom;
            m_ready   = ($urandom_range(0, 1) == 1);
            check("rnd_m_valid", m_valid, (outq.size() != 0) ? 1 : 0);
            if (m_valid && m_ready && outq.size() != 0) begin
                exp_item = outq.pop_front();
                check("rnd_data", m_data, exp_item[43:12]);
                check("rnd_mode", m_mode, 32'(exp_item[11:8]));
                check("rnd_seq", m_seq, 32'(exp_item[7:0]));
                $display("pop seq=%0d mode=%0d data=0x%08h", m_seq, m_mode, m_data);
                last_seq = m_seq;
                got++;
            end
            tick();
            if (drv_res) begin
                tag_item = pend.pop_front();
                outq.push_back({res_data, tag_item});
            end
            if (drv_iss) begin
                pend.push_back({iss_mode, mseq});
                mseq++;
                issued++;
            end
            cyc++;
        end
        iss_valid = 0; res_valid = 0; m_ready = 0;
        check("rnd_received", 32'(got), 300);
        check("rnd_last_seq", last_seq, 43);
        check("rnd_proto_err", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
